meter_display: RTL

Display back-end for the parking meter. It sits directly downstream of the meter's 14-bit binary time counter and converts each new count to four BCD digits with a sequential shift-add-3 converter. It then drives the four-digit 7-segment display, and blinks the whole display while the remaining time is below the low-time threshold.

---
 rtl/meter_pkg.sv | 35 +++
 rtl/bin2bcd_seq.sv | 61 ++++++
 rtl/meter_display.sv | 73 +++++++
 3 files changed

// File: rtl/meter_pkg.sv
// meter_pkg: shared widths, converter states and 7-segment helpers for the meter display.
package meter_pkg;
  localparam int BIN_W = 14;
  localparam int BCD_W = 16;
  localparam int MAX_COUNT = 9999;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
  // active-low segments, bit 0 = a ... bit 6 = g
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction
  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    logic [BCD_W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter with a one-deep latest-wins request buffer.
module bin2bcd_seq
  import meter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);
  conv_state_t r_state, w_state_n;
  logic [BCD_W+BIN_W-1:0] r_sr, w_sr_adj;
  logic [3:0] r_cnt;
  logic r_pend_v, r_done, w_load, w_last;
  logic [BIN_W-1:0] r_pend, w_src;
  logic [BCD_W-1:0] r_bcd;
  function automatic logic [BIN_W-1:0] sat(input logic [BIN_W-1:0] b);
    return b > BIN_W'(MAX_COUNT) ? BIN_W'(MAX_COUNT) : b;
  endfunction
  always_comb begin
    w_last = r_state == SHIFT && r_cnt == 4'd14;
    w_src = start ? bin : r_pend;
    w_load = (r_state == IDLE && start) || (r_state == DONE && (start || r_pend_v));
    w_state_n = w_load ? SHIFT : r_state == SHIFT ? (w_last ? DONE : SHIFT) : IDLE;
    w_sr_adj = r_sr;
    for (int i = 0; i < 4; i++)
      if (r_sr[BIN_W+4*i +: 4] >= 4'd5) w_sr_adj[BIN_W+4*i +: 4] = r_sr[BIN_W+4*i +: 4] + 4'd3;
  end
  // count 14 is the extra cycle that publishes the result, giving a 16-cycle turnaround
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sr <= '0;
      r_cnt <= '0;
      r_pend_v <= 1'b0;
      r_pend <= '0;
      r_bcd <= '0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_done <= w_last;
      if (w_load) begin
        r_sr <= {{BCD_W{1'b0}}, sat(w_src)};
        r_cnt <= '0;
      end else if (r_state == SHIFT && !w_last) begin
        r_sr <= w_sr_adj << 1;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) r_bcd <= r_sr[BCD_W+BIN_W-1:BIN_W];
      if (start && r_state == SHIFT) begin
        r_pend <= bin;
        r_pend_v <= 1'b1;
      end else if (r_state == DONE) r_pend_v <= 1'b0;
    end
  end
  assign busy = r_state != IDLE;
  assign done = r_done;
  assign bcd = r_bcd;
endmodule

// File: rtl/meter_display.sv
// meter_display: converts the meter count to BCD and drives a multiplexed, flashing 4-digit 7-segment display.
module meter_display
  import meter_pkg::*;
#(
  parameter int SCAN_DIV = 100_000,
  parameter int FLASH_DIV = 100_000_000,
  parameter int FLASH_THRESH = 200,
  parameter int LZB = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] count_bin,
  input  logic             count_valid,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic [BCD_W-1:0] bcd_out,
  output logic             conv_done,
  output logic             busy
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int FW = FLASH_DIV > 1 ? $clog2(FLASH_DIV) : 1;
  localparam logic [BCD_W-1:0] THRESH_BCD = to_bcd(FLASH_THRESH);
  localparam bit FLASH_ALL = FLASH_THRESH > MAX_COUNT;
  logic [SW-1:0] r_scan_cnt;
  logic [FW-1:0] r_flash_cnt;
  logic [1:0] r_idx, w_sel;
  logic r_phase, r_on, w_tick, w_tog, w_phase_n, w_on_n, w_flash, w_blank;
  logic [3:0] r_an, w_an, w_digit;
  logic [6:0] r_seg, w_seg;
  bin2bcd_seq u_conv (
    .clk  (clk),
    .rst_n(rst_n),
    .start(count_valid),
    .bin  (count_bin),
    .busy (busy),
    .done (conv_done),
    .bcd  (bcd_out)
  );
  // the slot being shown is the index value just before its increment
  always_comb begin
    w_tick = r_scan_cnt == SW'(SCAN_DIV - 1);
    w_tog = r_flash_cnt == FW'(FLASH_DIV - 1);
    w_phase_n = r_phase ^ w_tog;
    w_on_n = r_on | w_tick;
    w_sel = w_tick ? r_idx : r_idx - 2'd1;
    w_digit = bcd_out[{w_sel, 2'b00} +: 4];
    w_blank = LZB != 0 && w_sel != 2'd0 && (bcd_out >> {w_sel, 2'b00}) == '0;
    w_flash = FLASH_ALL || bcd_out < THRESH_BCD;
    w_an = (!w_on_n || (w_flash && w_phase_n)) ? 4'b1111 : ~(4'b0001 << w_sel);
    w_seg = (!w_on_n || w_blank) ? SEG_BLANK : seg_decode(w_digit);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_flash_cnt <= '0;
      r_phase <= 1'b0;
      r_on <= 1'b0;
      r_idx <= '0;
      r_an <= 4'b1111;
      r_seg <= SEG_BLANK;
    end else begin
      r_scan_cnt <= w_tick ? '0 : r_scan_cnt + 1'b1;
      r_flash_cnt <= w_tog ? '0 : r_flash_cnt + 1'b1;
      r_phase <= w_phase_n;
      r_on <= w_on_n;
      if (w_tick) r_idx <= r_idx + 2'd1;
      r_an <= w_an;
      r_seg <= w_seg;
    end
  end
  assign an = r_an;
  assign seg = r_seg;
endmodule
